traffic_intersection_ctrl: RTL and testbench



---
 rtl/traffic_intersection_ctrl.sv | 116 +++++++++++
 tb/tb_traffic_intersection_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_intersection_ctrl.sv
// Two-road intersection scheduler: main road owns green by default, side road and
// pedestrian requests are latched and served after the main road's minimum green.
module traffic_intersection_ctrl #(
  parameter int MIN_GREEN = 8,
  parameter int SIDE_MIN  = 4,
  parameter int SIDE_MAX  = 10,
  parameter int YELLOW    = 3,
  parameter int ALLRED    = 2,
  parameter int TW        = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       side_req,
  input  logic       ped_req,
  output logic [3:0] main_light,
  output logic [3:0] side_light,
  output logic       ped_walk,
  output logic [2:0] phase
);

  localparam logic [2:0] S_INIT   = 3'd0;
  localparam logic [2:0] S_MAIN_G = 3'd1;
  localparam logic [2:0] S_MAIN_Y = 3'd2;
  localparam logic [2:0] S_RED1   = 3'd3;
  localparam logic [2:0] S_SIDE_G = 3'd4;
  localparam logic [2:0] S_SIDE_Y = 3'd5;
  localparam logic [2:0] S_RED2   = 3'd6;

  localparam logic [3:0] L_BLACK  = 4'b1000;
  localparam logic [3:0] L_RED    = 4'b0100;
  localparam logic [3:0] L_GREEN  = 4'b0010;
  localparam logic [3:0] L_YELLOW = 4'b0001;

  // Last count value of each dwell: a phase of N cycles exits when cnt == N-1.
  localparam logic [TW-1:0] MAIN_G_LAST = TW'(MIN_GREEN - 1);
  localparam logic [TW-1:0] SIDE_MIN_LAST = TW'(SIDE_MIN - 1);
  localparam logic [TW-1:0] SIDE_MAX_LAST = TW'(SIDE_MAX - 1);
  localparam logic [TW-1:0] YELLOW_LAST = TW'(YELLOW - 1);
  localparam logic [TW-1:0] ALLRED_LAST = TW'(ALLRED - 1);
  localparam logic [TW-1:0] CNT_MAX = {TW{1'b1}};

  logic [2:0]    state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic          side_pend_q, side_pend_d;
  logic          ped_pend_q, ped_pend_d;
  logic          walk_en_q, walk_en_d;

  // NOTE: every variable gets a default at the top of always_comb so no path
  // through the case statements can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_INIT:   state_d = S_MAIN_G;
      S_MAIN_G: if (cnt_q >= MAIN_G_LAST && (side_pend_q || ped_pend_q)) state_d = S_MAIN_Y;
      S_MAIN_Y: if (cnt_q == YELLOW_LAST) state_d = S_RED1;
      S_RED1:   if (cnt_q == ALLRED_LAST) state_d = S_SIDE_G;
      S_SIDE_G: if ((cnt_q >= SIDE_MIN_LAST && !side_req) || cnt_q == SIDE_MAX_LAST)
                  state_d = S_SIDE_Y;
      S_SIDE_Y: if (cnt_q == YELLOW_LAST) state_d = S_RED2;
      S_RED2:   if (cnt_q == ALLRED_LAST) state_d = S_MAIN_G;
      default:  state_d = S_INIT;
    endcase

    if (state_d != state_q)     cnt_d = '0;
    else if (cnt_q == CNT_MAX)  cnt_d = cnt_q;
    else                        cnt_d = cnt_q + TW'(1);

    side_pend_d = side_pend_q | (side_req && state_q != S_SIDE_G);
    ped_pend_d  = ped_pend_q  | (ped_req  && state_q != S_SIDE_G);
    walk_en_d   = walk_en_q;

    // Entering side green consumes the pending requests; the clear beats a
    // request arriving in the same cycle.
    if (state_q == S_RED1 && state_d == S_SIDE_G) begin
      walk_en_d   = ped_pend_q;
      side_pend_d = 1'b0;
      ped_pend_d  = 1'b0;
    end
    if (state_q == S_SIDE_G && state_d == S_SIDE_Y) walk_en_d = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_INIT;
      cnt_q       <= '0;
      side_pend_q <= 1'b0;
      ped_pend_q  <= 1'b0;
      walk_en_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      side_pend_q <= side_pend_d;
      ped_pend_q  <= ped_pend_d;
      walk_en_q   <= walk_en_d;
    end
  end

  always_comb begin
    main_light = L_BLACK;
    side_light = L_BLACK;
    unique case (state_q)
      S_MAIN_G: begin main_light = L_GREEN;  side_light = L_RED;    end
      S_MAIN_Y: begin main_light = L_YELLOW; side_light = L_RED;    end
      S_RED1,
      S_RED2:   begin main_light = L_RED;    side_light = L_RED;    end
      S_SIDE_G: begin main_light = L_RED;    side_light = L_GREEN;  end
      S_SIDE_Y: begin main_light = L_RED;    side_light = L_YELLOW; end
      default:  begin main_light = L_BLACK;  side_light = L_BLACK;  end
    endcase
    ped_walk = (state_q == S_SIDE_G) && walk_en_q;
    phase    = state_q;
  end

endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
// Self-checking bench: a phase/age behavioural model predicts lamps, walk and phase
// every cycle; directed scenarios pin the model with hand-computed dwell lengths.
module tb_traffic_intersection_ctrl;

  localparam int MIN_GREEN = 8;
  localparam int SIDE_MIN  = 4;
  localparam int SIDE_MAX  = 10;
  localparam int YELLOW    = 3;
  localparam int ALLRED    = 2;
  localparam int TW        = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       side_req = 1'b0;
  logic       ped_req = 1'b0;
  logic [3:0] main_light, side_light;
  logic       ped_walk;
  logic [2:0] phase;

  int checks = 0;
  int errors = 0;

  traffic_intersection_ctrl #(
    .MIN_GREEN(MIN_GREEN), .SIDE_MIN(SIDE_MIN), .SIDE_MAX(SIDE_MAX),
    .YELLOW(YELLOW), .ALLRED(ALLRED), .TW(TW)
  ) dut (
    .clk(clk), .rst(rst), .side_req(side_req), .ped_req(ped_req),
    .main_light(main_light), .side_light(side_light),
    .ped_walk(ped_walk), .phase(phase)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phase number (0..6, spec encoding) plus how long it has been held.
  int m_ph = 0;
  int m_age = 0;
  bit m_sp = 0, m_pp = 0, m_we = 0;
  bit m_valid = 0;

  function automatic bit model_leaves(input int ph, input int age, input bit sreq, input bit pend);
    case (ph)
      0: return 1'b1;
      1: return (age >= MIN_GREEN - 1) && pend;
      2, 5: return age == YELLOW - 1;
      3, 6: return age == ALLRED - 1;
      4: return ((age >= SIDE_MIN - 1) && !sreq) || (age == SIDE_MAX - 1);
      default: return 1'b1;
    endcase
  endfunction

  always @(posedge clk) begin
    bit leave, n_sp, n_pp, n_we;
    if (rst) begin
      m_ph = 0; m_age = 0; m_sp = 0; m_pp = 0; m_we = 0;
    end else begin
      leave = model_leaves(m_ph, m_age, side_req, m_sp | m_pp);
      n_sp = m_sp | (m_ph != 4 && side_req);
      n_pp = m_pp | (m_ph != 4 && ped_req);
      n_we = m_we;
      if (leave && m_ph == 3) begin n_we = m_pp; n_sp = 0; n_pp = 0; end
      if (leave && m_ph == 4) n_we = 0;
      m_sp = n_sp; m_pp = n_pp; m_we = n_we;
      if (leave) begin
        m_ph = (m_ph == 6) ? 1 : m_ph + 1;
        m_age = 0;
      end else begin
        m_age = m_age + 1;
      end
    end
    m_valid = 1;
  end

  function automatic logic [7:0] lamps(input int ph);
    case (ph)
      1: return {4'b0010, 4'b0100};
      2: return {4'b0001, 4'b0100};
      3, 6: return {4'b0100, 4'b0100};
      4: return {4'b0100, 4'b0010};
      5: return {4'b0100, 4'b0001};
      default: return {4'b1000, 4'b1000};
    endcase
  endfunction

  always @(negedge clk) begin
    logic [7:0] exp_l;
    logic [2:0] exp_ph;
    if (m_valid) begin
      exp_l = lamps(m_ph);
      exp_ph = m_ph[2:0];
      check("model_main", main_light, exp_l[7:4]);
      check("model_side", side_light, exp_l[3:0]);
      check("model_walk", ped_walk, (m_ph == 4) && m_we);
      check("model_phase", phase, exp_ph);
    end
  end

  task automatic wait_model(input int p, input int a);
    int k = 0;
    while (!(m_ph == p && m_age == a) && k < 400) begin
      @(negedge clk);
      k++;
    end
    if (k >= 400) begin
      checks++; errors++;
      $display("FAIL wait_model phase=%0d age=%0d timed out", p, a);
    end
  endtask

  // Waits for phase p, then counts consecutive cycles in it (up to limit) and
  // how many of them had ped_walk high.
  task automatic measure(input int p, input int limit, output int n, output int walks);
    int k = 0;
    logic [2:0] pp;
    pp = p[2:0];
    n = 0;
    walks = 0;
    while (phase !== pp && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (k >= 300) begin
      checks++; errors++;
      $display("FAIL measure_wait phase=%0d timed out", p);
    end
    while (phase === pp && n < limit) begin
      n++;
      if (ped_walk === 1'b1) walks++;
      @(negedge clk);
    end
  endtask

  task automatic pulse_side();
    side_req = 1'b1;
    @(negedge clk);
    side_req = 1'b0;
  endtask

  initial begin
    int n, w;

    // Reset then idle.
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("rst_main", main_light, 4'b1000);
      check("rst_side", side_light, 4'b1000);
      check("rst_walk", ped_walk, 1'b0);
      check("rst_phase", phase, 3'd0);
    end
    rst = 1'b0;
    check("init_phase", phase, 3'd0);
    @(negedge clk);
    check("first_main_g_phase", phase, 3'd1);
    check("first_main_g_main", main_light, 4'b0010);
    check("first_main_g_side", side_light, 4'b0100);
    repeat (60) @(negedge clk);
    check("idle_hold", phase, 3'd1);
    // Saturated timer still satisfies the minimum green, so yellow follows the latch.
    pulse_side();
    check("sat_latch_cycle", phase, 3'd1);
    @(negedge clk);
    check("sat_to_yellow", phase, 3'd2);

    // Side pulse at MAIN_G cnt=2 on a fresh main green.
    wait_model(1, 2);
    pulse_side();
    measure(2, 50, n, w); check("p2_main_y_len", n, 3);
    measure(3, 50, n, w); check("p2_red1_len", n, 2);
    measure(4, 50, n, w); check("p2_side_g_len", n, 4); check("p2_walk", w, 0);
    measure(5, 50, n, w); check("p2_side_y_len", n, 3);
    measure(6, 50, n, w); check("p2_red2_len", n, 2);

    // Side sensor held.
    side_req = 1'b1;
    measure(4, 50, n, w); check("p3_side_g_max", n, SIDE_MAX);
    measure(5, 50, n, w); check("p3_side_y_len", n, 3);
    measure(6, 50, n, w); check("p3_red2_len", n, 2);
    measure(1, 50, n, w); check("p3_main_g_min", n, MIN_GREEN);
    side_req = 1'b0;

    // Pedestrian only.
    wait_model(1, 20);
    ped_req = 1'b1;
    @(negedge clk);
    ped_req = 1'b0;
    check("p4_latch_cycle", phase, 3'd1);
    @(negedge clk);
    check("p4_yellow", phase, 3'd2);
    measure(4, 50, n, w); check("p4_side_g_len", n, 4); check("p4_walk_all", w, 4);
    measure(5, 50, n, w); check("p4_side_y_walk", w, 0);

    // Reset mid-service.
    wait_model(1, 10);
    ped_req = 1'b1;
    @(negedge clk);
    ped_req = 1'b0;
    wait_model(4, 1);
    check("p5_walk_before", ped_walk, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("p5_main", main_light, 4'b1000);
    check("p5_side", side_light, 4'b1000);
    check("p5_walk", ped_walk, 1'b0);
    rst = 1'b0;
    measure(1, 50, n, w); check("p5_no_pend", n, 50);

    // Clear-vs-set race on the last RED1 cycle.
    pulse_side();
    wait_model(3, ALLRED - 1);
    side_req = 1'b1;
    ped_req = 1'b1;
    @(negedge clk);
    side_req = 1'b0;
    ped_req = 1'b0;
    measure(4, 50, n, w); check("p6_side_g_len", n, 4); check("p6_walk", w, 0);
    measure(1, 50, n, w); check("p6_cleared", n, 50);
    // Request in RED2 is carried into the next round.
    pulse_side();
    wait_model(6, 0);
    pulse_side();
    measure(1, 50, n, w); check("p6_red2_main_g", n, MIN_GREEN);
    measure(4, 50, n, w); check("p6_red2_served", n, 4);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      side_req = ($urandom_range(0, 3) == 0);
      ped_req  = ($urandom_range(0, 15) == 0);
      rst      = ($urandom_range(0, 299) == 0);
    end
    rst = 1'b0;
    side_req = 1'b0;
    ped_req = 1'b0;
    repeat (5) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
